// File: rtl/patternbuf_ctrl.sv
// Control front-end for patternbuf: registered one-hot read/write selects,
// processor/host write arbitration and the whole-buffer serial load sequencer.
module patternbuf_ctrl #(
  parameter int unsigned BUFFER_SIZE  = 22,
  parameter int unsigned BUFFER_WIDTH = 8,
  parameter int unsigned ADDR_W       = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic                    p_wr_req,
  input  logic [ADDR_W-1:0]       p_wr_addr,
  input  logic [BUFFER_WIDTH-1:0] p_wr_data,
  output logic                    p_wr_gnt,
  input  logic                    h_wr_req,
  input  logic [ADDR_W-1:0]       h_wr_addr,
  input  logic [BUFFER_WIDTH-1:0] h_wr_data,
  output logic                    h_wr_gnt,
  input  logic                    load_start,
  input  logic                    load_abort,
  input  logic                    load_valid,
  input  logic [BUFFER_WIDTH-1:0] load_byte,
  output logic                    load_ready,
  output logic                    load_busy,
  output logic                    load_done,
  output logic [BUFFER_SIZE-1:0]  fieldp,
  output logic [BUFFER_SIZE-1:0]  fieldwp,
  output logic [BUFFER_WIDTH-1:0] field_in,
  output logic                    field_write,
  output logic                    ssel,
  output logic                    sin
);

  localparam int unsigned CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam int unsigned BIT_W = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic RR_PROC = 1'b0;
  localparam logic RR_HOST = 1'b1;

  logic [1:0]              state, state_nxt;
  logic [CNT_W-1:0]        byte_cnt, byte_cnt_nxt;
  logic [BIT_W-1:0]        bit_cnt, bit_cnt_nxt;
  logic [BUFFER_WIDTH-1:0] shreg, shreg_nxt;
  logic                    ssel_nxt, sin_nxt, done_nxt;
  logic                    rr_last;

  // Out-of-range addresses decode to an all-zero select.
  function automatic logic [BUFFER_SIZE-1:0] decode(input logic [ADDR_W-1:0] a);
    decode = '0;
    if (32'(a) < BUFFER_SIZE) decode = BUFFER_SIZE'(1) << a;
  endfunction

  assign load_busy  = (state != IDLE);
  assign load_ready = (state == FETCH) && !load_abort;

  // Write arbiter: only in IDLE, and load_start takes the cycle.
  always_comb begin
    p_wr_gnt = 1'b0;
    h_wr_gnt = 1'b0;
    if (!reset && state == IDLE && !load_start) begin
      if (p_wr_req && h_wr_req) begin
        p_wr_gnt = (rr_last == RR_HOST);
        h_wr_gnt = (rr_last == RR_PROC);
      end else begin
        p_wr_gnt = p_wr_req;
        h_wr_gnt = h_wr_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fieldp      <= '0;
      fieldwp     <= '0;
      field_in    <= '0;
      field_write <= 1'b0;
      rr_last     <= RR_HOST;
    end else begin
      fieldp      <= decode(rd_addr);
      field_write <= p_wr_gnt | h_wr_gnt;
      if (p_wr_gnt) begin
        fieldwp  <= decode(p_wr_addr);
        field_in <= p_wr_data;
      end else if (h_wr_gnt) begin
        fieldwp  <= decode(h_wr_addr);
        field_in <= h_wr_data;
      end else begin
        fieldwp  <= '0;
      end
      // Round-robin pointer moves only when both sides contended.
      if (p_wr_req && h_wr_req && (p_wr_gnt || h_wr_gnt))
        rr_last <= h_wr_gnt ? RR_HOST : RR_PROC;
    end
  end

  // Serial load sequencer; ssel/sin are registered from *_nxt.
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    ssel_nxt     = 1'b0;
    sin_nxt      = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_nxt    = FETCH;
          byte_cnt_nxt = CNT_W'(BUFFER_SIZE);
        end
      end
      FETCH: begin
        if (load_valid) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = '0;
          shreg_nxt   = load_byte << 1;
          ssel_nxt    = 1'b1;
          sin_nxt     = load_byte[BUFFER_WIDTH-1];
        end
      end
      SHIFT: begin
        if (bit_cnt == BIT_W'(BUFFER_WIDTH - 1)) begin
          byte_cnt_nxt = byte_cnt - CNT_W'(1);
          state_nxt    = (byte_cnt == CNT_W'(1)) ? DONE : FETCH;
          done_nxt     = (byte_cnt == CNT_W'(1));
        end else begin
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
          ssel_nxt    = 1'b1;
          sin_nxt     = shreg[BUFFER_WIDTH-1];
          shreg_nxt   = shreg << 1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (load_abort && state != IDLE) begin
      state_nxt = IDLE;
      ssel_nxt  = 1'b0;
      sin_nxt   = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      ssel      <= 1'b0;
      sin       <= 1'b0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      ssel      <= ssel_nxt;
      sin       <= sin_nxt;
      load_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_patternbuf_ctrl.sv
// Scoreboard bench for patternbuf_ctrl: a driver predicts grants, read selects,
// write issues and load images; a monitor compares them and models patternbuf.
module tb_patternbuf_ctrl;

  localparam int unsigned SZ  = 22;
  localparam int unsigned W   = 8;
  localparam int unsigned AW  = 5;
  localparam int unsigned IMG = SZ * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] rd_addr = '0;
  logic          p_wr_req = 1'b0, h_wr_req = 1'b0;
  logic [AW-1:0] p_wr_addr = '0, h_wr_addr = '0;
  logic [W-1:0]  p_wr_data = '0, h_wr_data = '0;
  logic          p_wr_gnt, h_wr_gnt;
  logic          load_start = 1'b0, load_abort = 1'b0, load_valid = 1'b0;
  logic [W-1:0]  load_byte = '0;
  logic          load_ready, load_busy, load_done;
  logic [SZ-1:0] fieldp, fieldwp;
  logic [W-1:0]  field_in;
  logic          field_write, ssel, sin;

  always #5 clk = ~clk;

  patternbuf_ctrl #(.BUFFER_SIZE(SZ), .BUFFER_WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr),
    .p_wr_req(p_wr_req), .p_wr_addr(p_wr_addr), .p_wr_data(p_wr_data), .p_wr_gnt(p_wr_gnt),
    .h_wr_req(h_wr_req), .h_wr_addr(h_wr_addr), .h_wr_data(h_wr_data), .h_wr_gnt(h_wr_gnt),
    .load_start(load_start), .load_abort(load_abort), .load_valid(load_valid),
    .load_byte(load_byte), .load_ready(load_ready), .load_busy(load_busy),
    .load_done(load_done), .fieldp(fieldp), .fieldwp(fieldwp), .field_in(field_in),
    .field_write(field_write), .ssel(ssel), .sin(sin)
  );

  typedef struct { int tag; logic [SZ-1:0] sel; logic [W-1:0] data; } wr_exp_t;
  typedef struct { int tag; logic [SZ-1:0] sel; } rd_exp_t;

  wr_exp_t        wq[$];
  rd_exp_t        fq[$];
  logic [IMG-1:0] lq[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  bit m_busy = 1'b0;
  bit rr_host = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic logic [SZ-1:0] onehot(input logic [AW-1:0] a);
    logic [SZ-1:0] r;
    r = '0;
    for (int k = 0; k < int'(SZ); k++)
      if (int'(a) == k) r[k] = 1'b1;
    return r;
  endfunction

  // Monitor: scoreboard pops plus a behavioural model of patternbuf.
  logic [IMG-1:0] img = '0;
  int             ssel_cnt = 0;
  logic [W-1:0]   last_in = '0;
  bit             prev_busy = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (fq.size() > 0 && fq[0].tag == cyc) begin
        chk("fieldp", fieldp, fq[0].sel);
        void'(fq.pop_front());
      end
      if (wq.size() > 0 && wq[0].tag == cyc) begin
        chk("field_write", field_write, 1);
        chk("fieldwp", fieldwp, wq[0].sel);
        chk("field_in", field_in, wq[0].data);
        last_in = wq[0].data;
        void'(wq.pop_front());
      end else begin
        chk("field_write_idle", field_write, 0);
        chk("fieldwp_idle", fieldwp, 0);
        chk("field_in_hold", field_in, last_in);
      end
      if (field_write === 1'b1) chk("write_vs_shift", ssel, 0);
      if (load_busy === 1'b1 && !prev_busy) ssel_cnt = 0;
      prev_busy = (load_busy === 1'b1);
      if (field_write === 1'b1) begin
        for (int k = 0; k < int'(SZ); k++)
          if (fieldwp[k]) img[k*W +: W] = field_in;
      end else if (ssel === 1'b1) begin
        img = {img[IMG-2:0], sin};
        ssel_cnt++;
      end
      if (load_done === 1'b1) begin
        if (lq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          chk("ssel_cycles", ssel_cnt, IMG);
          chk("load_image", img, lq[0]);
          void'(lq.pop_front());
        end
      end
      if (reset) last_in = '0;
    end
  end

  // One clock of stimulus: predict grants and selects, then advance.
  task automatic step(output bit acc, output bit dn);
    bit ep, eh;
    @(negedge clk);
    acc = load_valid && (load_ready === 1'b1);
    dn  = (load_done === 1'b1);
    ep = 1'b0;
    eh = 1'b0;
    if (!reset && !m_busy && !load_start) begin
      if (p_wr_req && h_wr_req) begin
        ep = rr_host;
        eh = !rr_host;
      end else begin
        ep = p_wr_req;
        eh = h_wr_req;
      end
    end
    chk("p_wr_gnt", p_wr_gnt, ep);
    chk("h_wr_gnt", h_wr_gnt, eh);
    if (ep) wq.push_back(wr_exp_t'{cyc + 1, onehot(p_wr_addr), p_wr_data});
    if (eh) wq.push_back(wr_exp_t'{cyc + 1, onehot(h_wr_addr), h_wr_data});
    if (p_wr_req && h_wr_req && (ep || eh)) rr_host = eh;
    if (reset) rr_host = 1'b1;
    fq.push_back(rd_exp_t'{cyc + 1, reset ? '0 : onehot(rd_addr)});
    if (reset || (m_busy && load_abort)) m_busy = 1'b0;
    else if (!m_busy && load_start) m_busy = 1'b1;
    else if (dn) m_busy = 1'b0;
    @(posedge clk);
    #1;
    if (ep) p_wr_req = 1'b0;
    if (eh) h_wr_req = 1'b0;
  endtask

  task automatic check_quiet(input bit full);
    @(negedge clk);
    chk("q_ssel", ssel, 0);
    chk("q_load_busy", load_busy, 0);
    chk("q_load_done", load_done, 0);
    chk("q_load_ready", load_ready, 0);
    if (full) begin
      chk("q_fieldp", fieldp, 0);
      chk("q_fieldwp", fieldwp, 0);
      chk("q_field_in", field_in, 0);
      chk("q_field_write", field_write, 0);
      chk("q_sin", sin, 0);
    end
    @(posedge clk);
    #1;
  endtask

  // stop_kind: 0 run to completion, 1 abort, 2 reset, a few cycles after stop_after bytes.
  task automatic run_load(input bit ramp, input bit stall, input int stop_kind, input int stop_after);
    logic [W-1:0]   bytes[SZ];
    logic [IMG-1:0] exp_img;
    int  idx, c0, since;
    bit  acc, dn, got_done;
    idx = 0; since = 0; got_done = 1'b0; exp_img = '0;
    for (int i = 0; i < int'(SZ); i++) begin
      bytes[i] = ramp ? W'(i) : W'($urandom);
      exp_img[(int'(SZ) - 1 - i)*W +: W] = bytes[i];
    end
    if (stop_kind == 0) lq.push_back(exp_img);
    load_start = 1'b1;
    c0 = cyc;
    step(acc, dn);
    load_start = 1'b0;
    for (int n = 0; n < 2000 && !got_done; n++) begin
      load_valid = (idx < int'(SZ)) && (!stall || $urandom_range(0, 2) != 0);
      if (idx < int'(SZ)) load_byte = bytes[idx];
      if (stall && n == 40) load_start = 1'b1;
      if (stop_kind != 0 && idx >= stop_after) begin
        since++;
        if (since == 4) begin
          if (stop_kind == 1) load_abort = 1'b1;
          else begin
            reset = 1'b1;
            rd_addr = AW'(7);
          end
          step(acc, dn);
          load_abort = 1'b0;
          reset = 1'b0;
          load_valid = 1'b0;
          check_quiet(stop_kind == 2);
          return;
        end
      end
      step(acc, dn);
      load_start = 1'b0;
      if (acc) idx++;
      if (dn) begin
        got_done = 1'b1;
        if (!stall) chk("done_latency", cyc - 1 - c0, 199);
      end
    end
    load_valid = 1'b0;
    if (!got_done) chk("load_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, dn;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(acc, dn);
    step(acc, dn);
    reset = 1'b0;
    check_quiet(1'b1);

    // Read decode incl. out-of-range address.
    rd_addr = AW'(5);  step(acc, dn);
    rd_addr = AW'(25); step(acc, dn);
    rd_addr = AW'(21); step(acc, dn);

    // Single processor write.
    p_wr_req = 1'b1; p_wr_addr = AW'(3); p_wr_data = 8'hA5;
    step(acc, dn);
    step(acc, dn);

    // Contention: both held for 4 cycles.
    for (int n = 0; n < 4; n++) begin
      p_wr_req = 1'b1; p_wr_addr = AW'(n);      p_wr_data = W'(8'h10 + n);
      h_wr_req = 1'b1; h_wr_addr = AW'(10 + n); h_wr_data = W'(8'h80 + n);
      step(acc, dn);
    end
    p_wr_req = 1'b0; h_wr_req = 1'b0;
    step(acc, dn);

    // Random write traffic including out-of-range addresses.
    for (int n = 0; n < 300; n++) begin
      rd_addr = AW'($urandom);
      if (!p_wr_req && $urandom_range(0, 1) == 1) begin
        p_wr_req = 1'b1; p_wr_addr = AW'($urandom); p_wr_data = W'($urandom);
      end
      if (!h_wr_req && $urandom_range(0, 1) == 1) begin
        h_wr_req = 1'b1; h_wr_addr = AW'($urandom); h_wr_data = W'($urandom);
      end
      step(acc, dn);
    end
    while (p_wr_req || h_wr_req) step(acc, dn);
    step(acc, dn);

    // Full ramp load with valid every cycle.
    run_load(1'b1, 1'b0, 0, 0);
    step(acc, dn);

    // Host write raised with load_start and held through the load.
    h_wr_req = 1'b1; h_wr_addr = AW'(9); h_wr_data = 8'h5A;
    run_load(1'b0, 1'b0, 0, 0);
    for (int n = 0; n < 3; n++) step(acc, dn);

    // Random stalls plus an ignored load_start mid-load.
    run_load(1'b0, 1'b1, 0, 0);
    step(acc, dn);

    // Abort after 3 bytes, then reset mid-shift.
    run_load(1'b0, 1'b0, 1, 3);
    for (int n = 0; n < 5; n++) step(acc, dn);
    p_wr_req = 1'b1; p_wr_addr = AW'(4); p_wr_data = 8'h3C;
    step(acc, dn);
    run_load(1'b0, 1'b0, 2, 2);
    for (int n = 0; n < 4; n++) step(acc, dn);

    // Load still works after abort/reset.
    run_load(1'b0, 1'b1, 0, 0);
    for (int n = 0; n < 4; n++) step(acc, dn);

    chk("wq_drained", wq.size(), 0);
    chk("lq_drained", lq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
